// File: rtl/fft_pkg.sv
// Shared FFT types and helpers: frame geometry, complex word layout, bit reversal
// and complex packing, plus the loader FSM state encodings.
package fft_pkg;

    localparam int WIDTH = 32;
    localparam int HALF  = WIDTH / 2;
    localparam int N     = 16;
    localparam int LOGN  = $clog2(N);

    typedef struct packed {
        logic [HALF-1:0] re;
        logic [HALF-1:0] im;
    } cplx_t;

    typedef enum logic { W_FILL = 1'b0, W_WAIT  = 1'b1 } wr_state_t;
    typedef enum logic { R_IDLE = 1'b0, R_DRAIN = 1'b1 } rd_state_t;

    function automatic logic [LOGN-1:0] bitrev(input logic [LOGN-1:0] idx);
        logic [LOGN-1:0] r;
        for (int i = 0; i < LOGN; i++) begin
            r[i] = idx[LOGN-1-i];
        end
        return r;
    endfunction

    function automatic cplx_t pack_cplx(input logic [HALF-1:0] re, input logic [HALF-1:0] im);
        cplx_t c;
        c.re = re;
        c.im = im;
        return c;
    endfunction

endpackage

// File: rtl/fft_tri_window.sv
// Triangular window w(n) = n for n < N/2, else N-n, normalised by N/2.
// Only instantiated when FFT_LOADER_WINDOW_EN is defined.
module fft_tri_window
    import fft_pkg::*;
(
    input  logic        [LOGN-1:0] n,
    input  logic signed [HALF-1:0] sample,
    output logic signed [HALF-1:0] windowed
);

    logic        [LOGN:0]        w_s;
    logic signed [HALF+LOGN-1:0] prod_s;

    // Window weight and scaled product; the product never exceeds HALF+LOGN bits
    always_comb begin
        if (n < LOGN'(N / 2)) begin
            w_s = {1'b0, n};
        end else begin
            w_s = (LOGN + 1)'(N) - {1'b0, n};
        end
        prod_s   = $signed({{LOGN{sample[HALF-1]}}, sample}) * $signed({{(HALF-1){1'b0}}, w_s});
        windowed = HALF'(prod_s >>> (LOGN - 1));
    end

endmodule

// File: rtl/fft_bitrev_loader.sv
// FFT input stage: packs real samples into complex words, stores them bit-reversed
// in a ping-pong buffer and streams completed frames out. FFT_LOADER_WINDOW_EN adds a triangular window.
module fft_bitrev_loader
    import fft_pkg::*;
#(
    parameter int IN_SHIFT = 1
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   s_valid,
    output logic                   s_ready,
    input  logic signed [HALF-1:0] s_data,
    output logic                   m_valid,
    input  logic                   m_ready,
    output logic        [WIDTH-1:0] m_data,
    output logic        [LOGN-1:0] m_index,
    output logic                   m_last
);

    localparam logic [LOGN-1:0] LAST_IDX  = LOGN'(N - 1);
    localparam logic [LOGN-1:0] FIRST_IDX = {LOGN{1'b0}};

    cplx_t                   mem_r [0:1][0:N-1];
    logic [1:0]              full_r;
    logic [1:0]              set_s;
    logic [1:0]              clr_s;
    logic [1:0]              full_next_s;
    logic                    wr_bank_r;
    logic                    rd_bank_r;
    logic [LOGN-1:0]         wr_cnt_r;
    logic [LOGN-1:0]         rd_cnt_r;
    logic [LOGN-1:0]         rd_nxt_s;
    wr_state_t               wr_state_r;
    rd_state_t               rd_state_r;
    logic                    s_ready_r;
    logic                    m_valid_r;
    logic                    m_last_r;
    cplx_t                   m_data_r;
    logic                    wr_fire_s;
    logic                    rd_fire_s;
    logic signed [HALF-1:0]  pre_s;
    logic signed [HALF-1:0]  re_s;

`ifdef FFT_LOADER_WINDOW_EN
    fft_tri_window u_window (
        .n        (wr_cnt_r),
        .sample   (s_data),
        .windowed (pre_s)
    );
`else
    assign pre_s = s_data;
`endif

    assign re_s = pre_s >>> IN_SHIFT;

    // Handshakes and next bank occupancy; a same-cycle set and clear both land,
    // so both FSMs decide on full_next_s to avoid a dead cycle
    always_comb begin
        wr_fire_s = s_valid && s_ready_r;
        rd_fire_s = m_valid_r && m_ready;
        rd_nxt_s  = rd_cnt_r + LOGN'(1);
        set_s     = 2'b00;
        clr_s     = 2'b00;
        if (wr_fire_s && (wr_cnt_r == LAST_IDX)) begin
            set_s[wr_bank_r] = 1'b1;
        end else begin
            set_s = 2'b00;
        end
        if (rd_fire_s && m_last_r) begin
            clr_s[rd_bank_r] = 1'b1;
        end else begin
            clr_s = 2'b00;
        end
        full_next_s = (full_r | set_s) & ~clr_s;
    end

    // Bank-full flags
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            full_r <= 2'b00;
        end else begin
            full_r <= full_next_s;
        end
    end

    // Write FSM and frame buffer: sample n lands at its bit-reversed slot
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_state_r <= W_FILL;
            wr_bank_r  <= 1'b0;
            wr_cnt_r   <= FIRST_IDX;
            s_ready_r  <= 1'b0;
            for (int b = 0; b < 2; b++) begin
                for (int i = 0; i < N; i++) begin
                    mem_r[b][i] <= {WIDTH{1'b0}};
                end
            end
        end else begin
            case (wr_state_r)
                W_FILL: begin
                    s_ready_r <= 1'b1;
                    if (wr_fire_s) begin
                        mem_r[wr_bank_r][bitrev(wr_cnt_r)] <= pack_cplx(re_s, {HALF{1'b0}});
                        if (wr_cnt_r == LAST_IDX) begin
                            wr_bank_r <= ~wr_bank_r;
                            wr_cnt_r  <= FIRST_IDX;
                            if (full_next_s[~wr_bank_r]) begin
                                wr_state_r <= W_WAIT;
                                s_ready_r  <= 1'b0;
                            end else begin
                                wr_state_r <= W_FILL;
                            end
                        end else begin
                            wr_cnt_r <= wr_cnt_r + LOGN'(1);
                        end
                    end else begin
                        wr_cnt_r <= wr_cnt_r;
                    end
                end
                W_WAIT: begin
                    if (!full_next_s[wr_bank_r]) begin
                        wr_state_r <= W_FILL;
                        s_ready_r  <= 1'b1;
                    end else begin
                        s_ready_r <= 1'b0;
                    end
                end
                default: begin
                    wr_state_r <= W_FILL;
                    s_ready_r  <= 1'b0;
                end
            endcase
        end
    end

    // Read FSM: output registers are reloaded only on acceptance, so a stall holds them
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_state_r <= R_IDLE;
            rd_bank_r  <= 1'b0;
            rd_cnt_r   <= FIRST_IDX;
            m_valid_r  <= 1'b0;
            m_last_r   <= 1'b0;
            m_data_r   <= {WIDTH{1'b0}};
        end else begin
            case (rd_state_r)
                R_IDLE: begin
                    if (full_next_s[rd_bank_r]) begin
                        rd_state_r <= R_DRAIN;
                        m_valid_r  <= 1'b1;
                        rd_cnt_r   <= FIRST_IDX;
                        m_last_r   <= 1'b0;
                        m_data_r   <= mem_r[rd_bank_r][FIRST_IDX];
                    end else begin
                        m_valid_r <= 1'b0;
                    end
                end
                R_DRAIN: begin
                    if (rd_fire_s && m_last_r) begin
                        rd_bank_r <= ~rd_bank_r;
                        rd_cnt_r  <= FIRST_IDX;
                        m_last_r  <= 1'b0;
                        if (full_next_s[~rd_bank_r]) begin
                            m_valid_r <= 1'b1;
                            m_data_r  <= mem_r[~rd_bank_r][FIRST_IDX];
                        end else begin
                            rd_state_r <= R_IDLE;
                            m_valid_r  <= 1'b0;
                        end
                    end else if (rd_fire_s) begin
                        rd_cnt_r <= rd_nxt_s;
                        m_last_r <= (rd_nxt_s == LAST_IDX);
                        m_data_r <= mem_r[rd_bank_r][rd_nxt_s];
                    end else begin
                        m_valid_r <= 1'b1;
                    end
                end
                default: begin
                    rd_state_r <= R_IDLE;
                    m_valid_r  <= 1'b0;
                end
            endcase
        end
    end

    assign s_ready = s_ready_r;
    assign m_valid = m_valid_r;
    assign m_data  = m_data_r;
    assign m_index = rd_cnt_r;
    assign m_last  = m_last_r;

endmodule

// File: tb/tb_fft_bitrev_loader.sv
// Self-checking bench for fft_bitrev_loader: a frame-level model (queue of completed
// frames, bit-reversed read order) checked every cycle, plus literal expectations.
module tb_fft_bitrev_loader;

    logic        clk;
    logic        rst_n;
    logic        s_valid;
    logic [15:0] s_data;
    logic        m_ready;

    logic        s_ready,  s_ready2;
    logic        m_valid,  m_valid2;
    logic [31:0] m_data,   m_data2;
    logic [3:0]  m_index,  m_index2;
    logic        m_last,   m_last2;

    int vectors;
    int miscompares;

    fft_bitrev_loader #(.IN_SHIFT(0)) dut (
        .clk(clk), .rst_n(rst_n), .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
        .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data), .m_index(m_index), .m_last(m_last)
    );

    fft_bitrev_loader #(.IN_SHIFT(1)) dut_sh (
        .clk(clk), .rst_n(rst_n), .s_valid(s_valid), .s_ready(s_ready2), .s_data(s_data),
        .m_valid(m_valid2), .m_ready(m_ready), .m_data(m_data2), .m_index(m_index2), .m_last(m_last2)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic int brev(input int k);
        int r;
        r = 0;
        for (int i = 0; i < 4; i++) begin
            r = r | (((k >> i) & 1) << (3 - i));
        end
        return r;
    endfunction

    // expected real part for raw sample at natural position n
    function automatic logic [15:0] exp_re(input logic [15:0] raw, input int n, input int sh);
        int v;
        int w;
        v = int'($signed(raw));
        w = (n < 8) ? n : 16 - n;
`ifdef FFT_LOADER_WINDOW_EN
        v = (v * w) >>> 3;
`endif
        v = v >>> sh;
        return v[15:0];
    endfunction

    // model state: completed frames (16 raw samples each, natural order), frame under construction
    logic [15:0] q_raw[$];
    logic [15:0] cur[16];
    int          wcnt;
    int          rk;
    int          mon_nf;
    int          mon_n;
    logic        prev_stall;
    logic [31:0] prev_data;
    logic [31:0] cap0[$];
    logic [31:0] cap1[$];

    always @(negedge clk) begin
        if (!rst_n) begin
            chk("rst_m_valid", {31'h0, m_valid}, 32'h0);
            chk("rst_m_last", {31'h0, m_last}, 32'h0);
            chk("rst_s_ready", {31'h0, s_ready}, 32'h0);
            chk("rst_m_index", {28'h0, m_index}, 32'h0);
            chk("rst_m_data", m_data, 32'h0);
            chk("rst_m_data_sh", m_data2, 32'h0);
            q_raw.delete();
            wcnt       = 0;
            rk         = 0;
            prev_stall = 1'b0;
        end else begin
            mon_nf = q_raw.size() / 16;
            chk("m_valid", {31'h0, m_valid}, {31'h0, mon_nf > 0});
            chk("s_ready", {31'h0, s_ready}, {31'h0, mon_nf < 2});
            chk("m_valid_sh", {31'h0, m_valid2}, {31'h0, mon_nf > 0});
            chk("s_ready_sh", {31'h0, s_ready2}, {31'h0, mon_nf < 2});
            if (m_valid && mon_nf > 0) begin
                mon_n = brev(rk);
                chk("m_data", m_data, {exp_re(q_raw[mon_n], mon_n, 0), 16'h0000});
                chk("m_data_sh", m_data2, {exp_re(q_raw[mon_n], mon_n, 1), 16'h0000});
                chk("m_index", {28'h0, m_index}, rk);
                chk("m_last", {31'h0, m_last}, {31'h0, rk == 15});
            end
            if (prev_stall) begin
                chk("stall_hold", m_data, prev_data);
            end
            if (m_valid && m_ready && mon_nf > 0) begin
                cap0.push_back(m_data);
                cap1.push_back(m_data2);
                rk++;
                if (rk == 16) begin
                    rk = 0;
                    repeat (16) void'(q_raw.pop_front());
                end
            end
            if (s_valid && s_ready) begin
                cur[wcnt] = s_data;
                wcnt++;
                if (wcnt == 16) begin
                    for (int i = 0; i < 16; i++) q_raw.push_back(cur[i]);
                    wcnt = 0;
                end
            end
            prev_stall = m_valid && !m_ready;
            prev_data  = m_data;
        end
    end

    task automatic push(input logic [15:0] d);
        int b;
        s_valid = 1'b1;
        s_data  = d;
        b       = 0;
        do begin
            @(negedge clk);
            b++;
        end while (!s_ready && b < 200);
        chk("push_accept", {31'h0, s_ready}, 32'h1);
        @(posedge clk);
        #1;
    endtask

    task automatic wait_idle();
        int b;
        b = 0;
        do begin
            @(negedge clk);
            b++;
        end while ((q_raw.size() != 0 || m_valid) && b < 2000);
        chk("drain_done", {31'h0, m_valid}, 32'h0);
        @(posedge clk);
        #1;
    endtask

    logic [15:0] ramp_exp [16] = '{16'd0, 16'd8, 16'd4, 16'd12, 16'd2, 16'd10, 16'd6, 16'd14,
                                   16'd1, 16'd9, 16'd5, 16'd13, 16'd3, 16'd11, 16'd7, 16'd15};

    initial begin
        int acc;
        int sent;
        int cyc;
        clk = 1'b0; rst_n = 1'b0; s_valid = 1'b0; s_data = 16'h0; m_ready = 1'b0;
        vectors = 0; miscompares = 0;
        repeat (3) @(negedge clk);
        #1 rst_n = 1'b1;
        @(posedge clk);
        #1;

        // ramp frame (or constant frame when windowed)
        cap0.delete();
        m_ready = 1'b1;
        for (int i = 0; i < 16; i++) begin
`ifdef FFT_LOADER_WINDOW_EN
            push(16'd1024);
`else
            push(16'(i));
`endif
        end
        s_valid = 1'b0;
        wait_idle();
        chk("frame0_count", cap0.size(), 32'd16);
`ifdef FFT_LOADER_WINDOW_EN
        chk("win_n0", cap0[0], 32'h0000_0000);
        chk("win_n8", cap0[1], {16'd1024, 16'h0000});
        chk("win_n4", cap0[2], {16'd512, 16'h0000});
        chk("win_n12", cap0[3], {16'd512, 16'h0000});
`else
        for (int k = 0; k < 16; k++) begin
            chk("ramp_lit", cap0[k], {ramp_exp[k], 16'h0000});
        end
`endif

        // most negative sample: arithmetic shift keeps the sign
        cap0.delete();
        cap1.delete();
        for (int i = 0; i < 16; i++) push(16'h8000);
        s_valid = 1'b0;
        wait_idle();
        chk("neg_noshift", cap0[1], 32'h8000_0000);
        chk("neg_shift", cap1[1], 32'hC000_0000);

        // backpressure: two frames buffered, writer then blocks
        m_ready = 1'b0;
        acc     = 0;
        s_valid = 1'b1;
        s_data  = 16'h0;
        for (int c = 0; c < 60; c++) begin
            @(negedge clk);
            if (s_valid && s_ready) acc++;
            @(posedge clk);
            #1;
            s_valid = (acc < 48);
            s_data  = 16'(acc * 37);
        end
        s_valid = 1'b0;
        chk("bp_accepted", acc, 32'd32);
        chk("bp_s_ready", {31'h0, s_ready}, 32'h0);
        m_ready = 1'b1;
        wait_idle();

        // reset with one frame pending and a partial frame in flight
        m_ready = 1'b0;
        for (int i = 0; i < 23; i++) push(16'(16'h1111 * (i % 7)));
        s_valid = 1'b0;
        chk("pre_rst_valid", {31'h0, m_valid}, 32'h1);
        rst_n = 1'b0;
        #1;
        chk("async_rst_valid", {31'h0, m_valid}, 32'h0);
        chk("async_rst_data", m_data, 32'h0);
        chk("async_rst_ready", {31'h0, s_ready}, 32'h0);
        @(negedge clk);
        #1 rst_n = 1'b1;
        m_ready = 1'b1;
        for (int i = 0; i < 16; i++) push(16'(100 + i * 3));
        s_valid = 1'b0;
        wait_idle();

        // 100 frames with random gaps and random downstream stalls
        sent = 0;
        cyc  = 0;
        while (sent < 1600 && cyc < 20000) begin
            @(negedge clk);
            if (s_valid && s_ready) sent++;
            @(posedge clk);
            #1;
            m_ready = 1'($urandom);
            s_valid = (sent < 1600) && ($urandom_range(3, 0) != 0);
            s_data  = 16'($urandom);
            cyc++;
        end
        s_valid = 1'b0;
        chk("rand_sent", sent, 32'd1600);
        m_ready = 1'b1;
        wait_idle();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
